// File: rtl/mc_data_mem.sv
`default_nettype none
// ============================================================================
// Module   : mc_data_mem
// Purpose  : Multi-cycle, word-organised data memory. It responds to the
//            processor memory-request handshake with a fixed access latency.
//            One request is outstanding at a time. Each read or write is
//            acknowledged by a single-cycle resp_valid pulse, LATENCY cycles
//            after the request is accepted.
// Ports    : clk        - system clock, rising edge
//            rst        - synchronous, active-high reset
//            req_valid  - requester presents a request
//            req_ready  - block accepts a request this cycle (IDLE)
//            req_wr     - 1 = write, 0 = read (sampled at acceptance)
//            req_addr   - byte address (sampled at acceptance)
//            req_wdata  - write data (sampled at acceptance)
//            resp_valid - one-cycle response / acknowledge pulse
//            resp_rdata - read data, held until the next read response
//            busy       - a transaction is outstanding
// Revision : 1.0 - initial release
// ============================================================================
module mc_data_mem #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 1024,
  parameter int LATENCY    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_wr,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  busy
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = 4;
  // The counter starts at LATENCY-2. The WAIT cycle that sees zero is the
  // last WAIT cycle, so RESP lands exactly LATENCY cycles after acceptance.
  localparam int LOAD  = (LATENCY > 1) ? (LATENCY - 2) : 0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    wr_q, wr_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]   rdata_q;

  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  // Byte address -> word index. Bit 0 and the bits above the index are
  // dropped, so the address is word-aligned and wraps modulo DEPTH.
  logic [IDX_W-1:0]        req_idx;
  assign req_idx = req_addr[IDX_W:1];

  generate
    if (ADDR_WIDTH > IDX_W + 1) begin : g_unused_hi
      logic unused_addr_bits;
      assign unused_addr_bits = ^{req_addr[0], req_addr[ADDR_WIDTH-1:IDX_W+1]};
    end else begin : g_unused_lo
      logic unused_addr_bits;
      assign unused_addr_bits = req_addr[0];
    end
  endgenerate

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          wr_d    = req_wr;
          idx_d   = req_idx;
          wdata_d = req_wdata;
          if (LATENCY > 1) begin
            cnt_d   = CNT_W'(LOAD);
            state_d = S_WAIT;
          end else begin
            state_d = S_RESP;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // The array is accessed on the edge that enters RESP. With LATENCY==1 that
  // edge is also the accepting edge, so the request fields come straight
  // from the ports instead of the (not yet loaded) latches.
  logic                  enter_resp;
  logic                  cmt_wr;
  logic [IDX_W-1:0]      cmt_idx;
  logic [DATA_WIDTH-1:0] cmt_data;

  assign enter_resp = (state_d == S_RESP) && (state_q != S_RESP);
  assign cmt_wr     = (state_q == S_IDLE) ? req_wr    : wr_q;
  assign cmt_idx    = (state_q == S_IDLE) ? req_idx   : idx_q;
  assign cmt_data   = (state_q == S_IDLE) ? req_wdata : wdata_q;

  // ---------------------------------------------------------------------
  // Control registers and read-data register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      if (enter_resp && !cmt_wr) begin
        rdata_q <= mem[cmt_idx];
      end
    end
  end

  // The storage array has no reset. A reset still blocks the commit, so an
  // aborted write never reaches the array.
  always_ff @(posedge clk) begin
    if (!rst && enter_resp && cmt_wr) begin
      mem[cmt_idx] <= cmt_data;
    end
  end

  assign req_ready  = (state_q == S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign resp_valid = (state_q == S_RESP);
  assign resp_rdata = rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_mc_data_mem.sv
`default_nettype none
// ============================================================================
// Module   : tb_mc_data_mem
// Purpose  : Self-checking bench for mc_data_mem. It uses two instances:
//            LATENCY=4 runs the directed and random transactions, and
//            LATENCY=1 runs a back-to-back stream. A word-indexed model
//            array tracks every committed write.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mc_data_mem;

  localparam int AW    = 16;
  localparam int DW    = 16;
  localparam int DEPTH = 1024;
  localparam int LAT_A = 4;
  localparam int LAT_B = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          a_valid, a_wr, a_ready, a_resp, a_busy;
  logic [AW-1:0] a_addr;
  logic [DW-1:0] a_wdata, a_rdata;
  logic          b_valid, b_wr, b_ready, b_resp, b_busy;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] b_wdata, b_rdata;

  mc_data_mem #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .LATENCY(LAT_A)) u_a (
    .clk(clk), .rst(rst), .req_valid(a_valid), .req_ready(a_ready), .req_wr(a_wr),
    .req_addr(a_addr), .req_wdata(a_wdata), .resp_valid(a_resp), .resp_rdata(a_rdata),
    .busy(a_busy)
  );

  mc_data_mem #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .LATENCY(LAT_B)) u_b (
    .clk(clk), .rst(rst), .req_valid(b_valid), .req_ready(b_ready), .req_wr(b_wr),
    .req_addr(b_addr), .req_wdata(b_wdata), .resp_valid(b_resp), .resp_rdata(b_rdata),
    .busy(b_busy)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Reference state: word-indexed contents, and the last read data returned.
  logic [DW-1:0] model_a [int];
  logic [DW-1:0] model_b [int];
  logic [DW-1:0] last_a, last_b;
  logic [AW-1:0] known_a [$];
  logic [AW-1:0] known_b [$];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int widx(input logic [AW-1:0] addr);
    return (int'(addr) / 2) % DEPTH;
  endfunction

  // Scatter the ignored address bits: a random bit 0 and random bits above
  // the word index.
  function automatic logic [AW-1:0] alias_addr(input logic [AW-1:0] addr);
    logic [AW-1:0] r;
    r = AW'($urandom);
    return {r[15:11], addr[10:1], r[0]};
  endfunction

  // One LATENCY_A transaction, checked cycle by cycle from acceptance
  // (cycle 0) to the first cycle back in IDLE (cycle LAT_A+1).
  task automatic txn_a(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                       input bit hold, input logic [AW-1:0] h_addr, input logic [DW-1:0] h_data,
                       input string tag);
    logic [DW-1:0] exp_rd;
    @(negedge clk);
    a_valid = 1'b1; a_wr = wr; a_addr = addr; a_wdata = wdata;
    check($sformatf("%s.ready_pre", tag), a_ready, 1);
    @(posedge clk); #1;
    if (wr) begin
      model_a[widx(addr)] = wdata;
      exp_rd = last_a;
    end else begin
      exp_rd = model_a[widx(addr)];
    end
    last_a = exp_rd;
    if (hold) begin
      a_valid = 1'b1; a_wr = 1'b1; a_addr = h_addr; a_wdata = h_data;
    end else begin
      a_valid = 1'b0; a_wr = 1'($urandom); a_addr = AW'($urandom); a_wdata = DW'($urandom);
    end
    for (int k = 1; k <= LAT_A + 1; k++) begin
      if (k > 1) begin
        @(posedge clk); #1;
      end
      check($sformatf("%s.ready@%0d", tag, k), a_ready, (k == LAT_A + 1));
      check($sformatf("%s.resp@%0d", tag, k), a_resp, (k == LAT_A));
      check($sformatf("%s.busy@%0d", tag, k), a_busy, (k <= LAT_A));
      if (k == LAT_A) check($sformatf("%s.rdata", tag), a_rdata, exp_rd);
    end
  endtask

  task automatic wr_a(input logic [AW-1:0] addr, input logic [DW-1:0] data, input string tag);
    txn_a(1'b1, addr, data, 1'b0, '0, '0, tag);
  endtask

  task automatic rd_a(input logic [AW-1:0] addr, input string tag);
    txn_a(1'b0, addr, '0, 1'b0, '0, '0, tag);
  endtask

  task automatic reset_hold(input int n, input string tag);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      check($sformatf("%s.a_ready%0d", tag, i), a_ready, 1);
      check($sformatf("%s.a_resp%0d", tag, i), a_resp, 0);
      check($sformatf("%s.a_busy%0d", tag, i), a_busy, 0);
      check($sformatf("%s.a_rdata%0d", tag, i), a_rdata, 0);
      check($sformatf("%s.b_ready%0d", tag, i), b_ready, 1);
      check($sformatf("%s.b_resp%0d", tag, i), b_resp, 0);
      check($sformatf("%s.b_busy%0d", tag, i), b_busy, 0);
      check($sformatf("%s.b_rdata%0d", tag, i), b_rdata, 0);
    end
    rst = 1'b0;
    last_a = '0;
    last_b = '0;
  endtask

  initial begin
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [DW-1:0] exp_b;
    int            op;

    rst = 1'b1;
    a_valid = 1'b0; a_wr = 1'b0; a_addr = '0; a_wdata = '0;
    b_valid = 1'b0; b_wr = 1'b0; b_addr = '0; b_wdata = '0;
    last_a = '0; last_b = '0;

    // Reset values held for three cycles.
    reset_hold(3, "rst_init");

    // Basic write/read.
    wr_a(16'h0010, 16'hBEEF, "wr_beef");
    rd_a(16'h0010, "rd_beef");

    // Alignment and wrap.
    wr_a(16'h0021, 16'h1234, "wr_odd");
    rd_a(16'h0020, "rd_align");
    wr_a(16'h0800, 16'h5A5A, "wr_wrap");
    rd_a(16'h0000, "rd_wrap");

    // Reset mid-operation: the aborted write must not commit.
    wr_a(16'h0040, 16'h0000, "wr_zero40");
    @(negedge clk);
    a_valid = 1'b1; a_wr = 1'b1; a_addr = 16'h0040; a_wdata = 16'hAAAA;
    @(posedge clk); #1;              // cycle 1
    a_valid = 1'b0;
    @(posedge clk); #1;              // cycle 2
    rst = 1'b1;
    @(posedge clk); #1;              // cycle 3, after the reset edge
    rst = 1'b0;
    last_a = '0; last_b = '0;
    check("midrst.ready", a_ready, 1);
    check("midrst.busy", a_busy, 0);
    check("midrst.resp", a_resp, 0);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check($sformatf("midrst.no_resp%0d", i), a_resp, 0);
    end
    rd_a(16'h0040, "rd_after_abort");

    // Request ignored while busy: the held write is taken only after IDLE.
    wr_a(16'h0002, 16'h1357, "wr_old2");
    txn_a(1'b0, 16'h0002, '0, 1'b1, 16'h0002, 16'hFFFF, "rd_hold");
    wr_a(16'h0002, 16'hFFFF, "wr_held");
    rd_a(16'h0002, "rd_new2");

    // Random transactions against the model, with read aliases.
    known_a.push_back(16'h0010);
    known_a.push_back(16'h0020);
    for (int i = 0; i < 12; i++) begin
      if ($urandom_range(0, 1) == 0) begin
        addr = AW'($urandom);
        data = DW'($urandom);
        known_a.push_back(addr);
        wr_a(addr, data, $sformatf("rnd_wr%0d", i));
      end else begin
        addr = alias_addr(known_a[$urandom_range(0, known_a.size() - 1)]);
        rd_a(addr, $sformatf("rnd_rd%0d", i));
      end
    end

    // Array contents survive reset.
    reset_hold(3, "rst_keep");
    rd_a(16'h0010, "keep_beef");
    rd_a(16'h0020, "keep_1234");
    rd_a(16'h0000, "keep_5a5a");

    // LATENCY=1 back-to-back stream. req_valid stays high. Even cycles are
    // IDLE (accept) and odd cycles are RESP (ignored garbage on req_*).
    exp_b = '0;
    @(posedge clk); #1;
    for (int c = 0; c < 32; c++) begin
      check($sformatf("b2b.ready@%0d", c), b_ready, (c % 2 == 0));
      check($sformatf("b2b.resp@%0d", c), b_resp, (c % 2 == 1));
      check($sformatf("b2b.busy@%0d", c), b_busy, (c % 2 == 1));
      if (c % 2 == 1) check($sformatf("b2b.rdata@%0d", c), b_rdata, exp_b);
      if (c % 2 == 0) begin
        op = c / 2;
        if (op % 2 == 0) begin
          addr = AW'($urandom);
          data = DW'($urandom);
          known_b.push_back(addr);
          model_b[widx(addr)] = data;
          exp_b = last_b;
          b_valid = 1'b1; b_wr = 1'b1; b_addr = addr; b_wdata = data;
        end else begin
          addr = alias_addr(known_b[$urandom_range(0, known_b.size() - 1)]);
          exp_b = model_b[widx(addr)];
          b_valid = 1'b1; b_wr = 1'b0; b_addr = addr; b_wdata = DW'($urandom);
        end
        last_b = exp_b;
      end else begin
        b_valid = 1'b1; b_wr = 1'($urandom); b_addr = AW'($urandom); b_wdata = DW'($urandom);
      end
      @(posedge clk); #1;
    end
    b_valid = 1'b0;
    @(posedge clk); #1;
    check("b2b.idle_ready", b_ready, 1);
    check("b2b.idle_resp", b_resp, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mc_data_mem.md
Name: mc_data_mem

Overview:
- Multi-cycle, word-organised data memory that acts as the responder to the processor's memory-request interface.
- It replaces the single-cycle data memory once the pipeline moves to a handshake-based memory path with fixed access latency.
- It accepts one read or write request at a time and returns a single-cycle response pulse after LATENCY cycles. Writes are acknowledged the same way as reads.

Parameters:
- ADDR_WIDTH, 16, byte-address width of req_addr.
- DATA_WIDTH, 16, word width.
- DEPTH, 1024, number of words in the array. Must be a power of two.
- LATENCY, 4, cycles from request acceptance to response. Legal range 1..15.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  1  requester presents a request.
- req_ready  output  1  block can accept a request this cycle.
- req_wr  input  1  1 = write, 0 = read; sampled at acceptance.
- req_addr  input  ADDR_WIDTH  byte address; sampled at acceptance.
- req_wdata  input  DATA_WIDTH  write data; sampled at acceptance.
- resp_valid  output  1  one-cycle response/acknowledge pulse.
- resp_rdata  output  DATA_WIDTH  read data; valid when resp_valid is high for a read.
- busy  output  1  a transaction is outstanding (state is not IDLE).

Behaviour:
- Reset, applied on a rising edge with rst=1:
  - state returns to IDLE and the latency counter goes to 0.
  - req_ready=1, resp_valid=0, busy=0, resp_rdata=0.
  - Array contents are NOT affected by reset.
- Reset mid-transaction: the outstanding transaction is aborted. No write is committed and no resp_valid is issued. The block is in IDLE on the next cycle.
- Clock and reset naming: clk and rst, one clock domain only.
- States:
  - IDLE: req_ready=1, busy=0.
  - WAIT: req_ready=0, busy=1; the counter counts down.
  - RESP: req_ready=0, busy=1, resp_valid=1 for exactly this one cycle.
- Acceptance: on an edge with state=IDLE and req_valid=1:
  - latch req_wr, word index and req_wdata.
  - if LATENCY>1, load the counter with LATENCY-2 and go to WAIT.
  - if LATENCY==1, go directly to RESP.
- WAIT: when the counter is 0, go to RESP on the next edge; otherwise decrement.
- Timing: resp_valid is high exactly LATENCY cycles after the accepting edge, for one cycle.
- RESP to IDLE is unconditional. req_ready is high again the cycle after resp_valid.
- Maximum throughput is one transaction per LATENCY+1 cycles.
- Word index = req_addr[log2(DEPTH):1]:
  - req_addr[0] is ignored (the address is forced word-aligned).
  - Address bits above the index are ignored, so the address wraps modulo DEPTH words.
- Write commit: the latched data is written to the array on the edge that enters RESP. resp_rdata is unchanged by a write.
- Read: resp_rdata is loaded from the array on the edge that enters RESP. It reflects all previously committed writes and holds its value until the next read response.
- req_valid, req_wr, req_addr and req_wdata are ignored whenever req_ready=0. Changes to them while busy have no effect on the outstanding transaction.
- At most one transaction is outstanding. There is no reordering and no combinational path from req_* to resp_*.

Test Plan:
- Basic write/read, LATENCY=4, after reset:
  - Write 0xBEEF to 0x0010, accepted at cycle 0 -> resp_valid high at cycle 4 only; req_ready low at cycles 1-4 and high at cycle 5.
  - Then read 0x0010 -> resp_rdata=0xBEEF with resp_valid 4 cycles after acceptance.
- Alignment and wrap, DEPTH=1024:
  - Write 0x1234 to 0x0021 -> a read of 0x0020 returns 0x1234.
  - Write 0x5A5A to 0x0800 -> a read of 0x0000 returns 0x5A5A.
- Reset mid-operation:
  - Write 0xAAAA to 0x0040 (previously 0x0000); assert rst at cycle 2 -> no resp_valid is seen.
  - req_ready=1 the cycle after reset.
  - A read of 0x0040 returns 0x0000.
- Request ignored while busy:
  - Read 0x0002 is accepted; a write of 0xFFFF to 0x0002 is held on req_* during cycles 1-4 -> the first response returns the old data.
  - The write is accepted only at cycle 5 and is acknowledged at cycle 9.
- LATENCY=1 back-to-back:
  - Keep req_valid high continuously with alternating reads and writes -> resp_valid on every second cycle and req_ready toggling 1,0,1,0.
  - Read data matches the last committed write.
- Reset values: hold rst for 3 cycles -> req_ready=1, resp_valid=0, busy=0, resp_rdata=0x0000 throughout; array contents written before reset are still readable afterwards.
